transition_capture: RTL and testbench

- Parametrised next-generation logic-analyser capture engine. Samples a CH_W-bit input bus every clock and writes one word per change-of-state into an external BRAM. Each word carries the sample plus a cycle delta since the previous word.
- Adds what the first generation lacks: mask/value trigger, arm/abort control, done/full status, word count, and keep-alive words on delta overflow.
- Sits between the register file (status/control/config0/config1) and the capture BRAM write port.

---
 rtl/transition_capture_pkg.sv | 24 ++
 rtl/capture_trigger.sv | 45 ++++
 rtl/transition_capture.sv | 214 +++++++++++++++++++++
 tb/tb_transition_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/transition_capture_pkg.sv
// Shared definitions for the transition_capture logic-analyser engine.
//   state_t      : capture sequencer states
//   ST_*         : bit positions inside the 32-bit status word
//   CTL_*        : bit positions inside the 32-bit control word
package transition_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int ST_BUSY      = 0;
  localparam int ST_TRIG      = 1;
  localparam int ST_DONE      = 2;
  localparam int ST_FULL      = 3;
  localparam int ST_ARMED     = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTL_ARM   = 0;
  localparam int CTL_ABORT = 1;

endpackage

// File: rtl/capture_trigger.sv
// Trigger front end for transition_capture.
// Holds registered copies of the trigger mask/value configuration and the
// previous arm level, and produces:
//   arm_rise : control arm bit went 0 -> 1 this cycle
//   hit      : (sample & mask) == (value & mask), mask == 0 always hits
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   arm               raw arm level from the control register
//   sample            current registered probe sample
//   mask_cfg          trigger mask from config0
//   value_cfg         trigger value from config1
//   arm_rise, hit     see above
module capture_trigger #(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            arm,
  input  logic [CH_W-1:0] sample,
  input  logic [CH_W-1:0] mask_cfg,
  input  logic [CH_W-1:0] value_cfg,
  output logic            arm_rise,
  output logic            hit
);

  logic            arm_prev;
  logic [CH_W-1:0] mask_q;
  logic [CH_W-1:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_prev <= 1'b0;
      mask_q   <= '0;
      value_q  <= '0;
    end else begin
      arm_prev <= arm;
      mask_q   <= mask_cfg;
      value_q  <= value_cfg;
    end
  end

  assign arm_rise = arm & ~arm_prev;
  assign hit      = ((sample & mask_q) == (value_q & mask_q));

endmodule

// File: rtl/transition_capture.sv
// Change-of-state capture engine. Samples a CH_W-bit probe bus every clock
// and writes {delta, sample} words into an external BRAM: one word at the
// trigger, one per change of the bus, and a keep-alive word whenever the
// delta counter saturates with the bus static.
// Optional build macro: INPUT_SYNC_EN adds a two-flop synchroniser ahead of
// the sample register (two extra cycles of capture latency).
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   status      [0] busy [1] triggered [2] done [3] full [4] armed,
//               [8+] words written, other bits 0
//   control     [0] arm (rising edge), [1] abort (level)
//   config0     [CH_W-1:0] trigger mask
//   config1     [CH_W-1:0] trigger value
//   datain      probe bus
//   dataout     {delta, sample} BRAM write word
//   we, en      BRAM write strobe / enable (identical one-cycle pulses)
//   address     BRAM write address (index of the word on dataout)
module transition_capture
  import transition_capture_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int TS_W   = 16,
  parameter int ADDR_W = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          status,
  input  logic [31:0]          control,
  input  logic [31:0]          config0,
  input  logic [31:0]          config1,
  input  logic [CH_W-1:0]      datain,
  output logic [TS_W+CH_W-1:0] dataout,
  output logic                 we,
  output logic                 en,
  output logic [ADDR_W-1:0]    address
);

  // The count reaches 2**ADDR_W on a full buffer, hence one extra bit; the
  // status word only has room for 24 count bits above ST_COUNT_LSB.
  localparam int CNT_W       = ADDR_W + 1;
  localparam int CNT_FIELD_W = (CNT_W > 24) ? 24 : CNT_W;

  localparam logic [TS_W-1:0]   DELTA_MAX = '1;
  localparam logic [TS_W-1:0]   DELTA_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;

  function automatic logic [TS_W-1:0] delta_sat_inc(input logic [TS_W-1:0] d);
    return (d == DELTA_MAX) ? d : d + DELTA_ONE;
  endfunction

  state_t            state, state_nx;
  logic [CH_W-1:0]   sample_q, sample_p;
  logic [TS_W-1:0]   delta;
  logic [TS_W-1:0]   wr_delta;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              trig_flag, full_flag;
  logic              arm_rise, hit, change, abort;
  logic              start, wr, set_trig;

  // ---- stage p0: probe sampling ----
`ifdef INPUT_SYNC_EN
  logic [CH_W-1:0] sync_p0, sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      sample_q <= '0;
      sample_p <= '0;
    end else begin
      sync_p0  <= datain;
      sync_p1  <= sync_p0;
      sample_q <= sync_p1;
      sample_p <= sample_q;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
      sample_p <= '0;
    end else begin
      sample_q <= datain;
      sample_p <= sample_q;
    end
  end
`endif

  assign change = (sample_q != sample_p);
  assign abort  = control[CTL_ABORT];

  capture_trigger #(.CH_W(CH_W)) u_trigger (
    .clk       (clk),
    .reset     (reset),
    .arm       (control[CTL_ARM]),
    .sample    (sample_q),
    .mask_cfg  (config0[CH_W-1:0]),
    .value_cfg (config1[CH_W-1:0]),
    .arm_rise  (arm_rise),
    .hit       (hit)
  );

  // ---- stage p1: write decision ----
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    wr       = 1'b0;
    wr_delta = delta;
    set_trig = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm_rise) begin
          start    = 1'b1;
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (abort) begin
          state_nx = DONE;
        end else if (hit) begin
          wr       = 1'b1;
          wr_delta = '0;
          set_trig = 1'b1;
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        // A saturated delta with a change still yields one word: the
        // transition word, whose delta field is all-ones anyway.
        if (abort) begin
          state_nx = DONE;
        end else if (change || (delta == DELTA_MAX)) begin
          wr = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (wr && (wr_ptr == ADDR_MAX)) begin
      state_nx = DONE;
    end
  end

  // ---- stage p2: registered write port and counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we        <= 1'b0;
      dataout   <= '0;
      address   <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      delta     <= '0;
      trig_flag <= 1'b0;
      full_flag <= 1'b0;
    end else begin
      state <= state_nx;
      we    <= wr;
      if (start) begin
        wr_ptr    <= '0;
        address   <= '0;
        count     <= '0;
        delta     <= '0;
        trig_flag <= 1'b0;
        full_flag <= 1'b0;
      end
      if (wr) begin
        dataout <= {wr_delta, sample_q};
        address <= wr_ptr;
        count   <= count + CNT_ONE;
        delta   <= '0;
        // The pointer parks on the last address instead of wrapping.
        if (wr_ptr == ADDR_MAX) begin
          full_flag <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + ADDR_ONE;
        end
      end else if (state == CAPTURE) begin
        delta <= delta_sat_inc(delta);
      end
      if (set_trig) begin
        trig_flag <= 1'b1;
      end
    end
  end

  assign en = we;

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = (state == ARMED) || (state == CAPTURE);
    status[ST_TRIG]  = trig_flag;
    status[ST_DONE]  = (state == DONE);
    status[ST_FULL]  = full_flag;
    status[ST_ARMED] = (state == ARMED);
    status[ST_COUNT_LSB +: CNT_FIELD_W] = count[CNT_FIELD_W-1:0];
  end

  logic unused_ctl;
  assign unused_ctl = ^control[31:2];

  if (CH_W < 32) begin : g_unused_cfg
    logic unused_cfg;
    assign unused_cfg = ^{config0[31:CH_W], config1[31:CH_W]};
  end

  if (CNT_W > CNT_FIELD_W) begin : g_unused_cnt
    logic unused_cnt;
    assign unused_cnt = ^count[CNT_W-1:CNT_FIELD_W];
  end

endmodule

// File: tb/tb_transition_capture.sv
// Directed bench for transition_capture built with CH_W=8, TS_W=4, ADDR_W=3
// so that keep-alive and buffer-full corners are reached in a few cycles.
module tb_transition_capture;

  localparam int CH_W   = 8;
  localparam int TS_W   = 4;
  localparam int ADDR_W = 3;
  localparam int DW     = TS_W + CH_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       status, control, config0, config1;
  logic [CH_W-1:0]   datain;
  logic [DW-1:0]     dataout;
  logic              we, en;
  logic [ADDR_W-1:0] address;

  always #5 clk = ~clk;

  transition_capture #(.CH_W(CH_W), .TS_W(TS_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .status  (status),
    .control (control),
    .config0 (config0),
    .config1 (config1),
    .datain  (datain),
    .dataout (dataout),
    .we      (we),
    .en      (en),
    .address (address)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    int                at;
  } wr_t;

  wr_t log_q[$];

  always @(negedge clk) begin : monitor
    wr_t w;
    if (we === 1'b1) begin
      w.addr = address;
      w.data = dataout;
      w.at   = cyc;
      log_q.push_back(w);
    end
  end

  typedef struct {
    logic              rst;
    logic [31:0]       ctl;
    logic [CH_W-1:0]   mask;
    logic [CH_W-1:0]   value;
    logic [CH_W-1:0]   din;
    logic              we;
    logic [DW-1:0]     data;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       st;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  logic [DW-1:0] ka_exp [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [CH_W-1:0] mask, input logic [CH_W-1:0] din);
    reset   = 1'b1;
    control = 32'd0;
    config0 = 32'(mask);
    config1 = 32'd0;
    datain  = din;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    control = 32'd0;
    config0 = 32'd0;
    config1 = 32'd0;
    datain  = '0;

    // rst, ctl, mask, value, din, we, data, addr, status
    // Mask/value trigger on bit7; bit0 toggles beforehand must not write.
    vt[0]  = '{1'b1, 32'd0, 8'h80, 8'h80, 8'h00, 1'b0, 12'h000, 3'd0, 32'h000};
    vt[1]  = '{1'b0, 32'd1, 8'h80, 8'h80, 8'h00, 1'b0, 12'h000, 3'd0, 32'h011};
    vt[2]  = '{1'b0, 32'd1, 8'h80, 8'h80, 8'h01, 1'b0, 12'h000, 3'd0, 32'h011};
    vt[3]  = '{1'b0, 32'd1, 8'h80, 8'h80, 8'h00, 1'b0, 12'h000, 3'd0, 32'h011};
    vt[4]  = '{1'b0, 32'd0, 8'h80, 8'h80, 8'h80, 1'b0, 12'h000, 3'd0, 32'h011};
    vt[5]  = '{1'b0, 32'd0, 8'h80, 8'h80, 8'h80, 1'b1, 12'h080, 3'd0, 32'h103};
    vt[6]  = '{1'b0, 32'd0, 8'h80, 8'h80, 8'h80, 1'b0, 12'h000, 3'd0, 32'h103};
    vt[7]  = '{1'b0, 32'd0, 8'h80, 8'h80, 8'h00, 1'b0, 12'h000, 3'd0, 32'h103};
    vt[8]  = '{1'b0, 32'd0, 8'h80, 8'h80, 8'h00, 1'b1, 12'h200, 3'd1, 32'h203};
    vt[9]  = '{1'b0, 32'd0, 8'h80, 8'h80, 8'h00, 1'b0, 12'h000, 3'd0, 32'h203};
    // Mask 0: immediate trigger, then 0x00 -> 0x01 with delta 5; an arm
    // edge during CAPTURE (rows 13->14) must be ignored.
    vt[10] = '{1'b1, 32'd0, 8'h00, 8'h00, 8'h00, 1'b0, 12'h000, 3'd0, 32'h000};
    vt[11] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h00, 1'b0, 12'h000, 3'd0, 32'h011};
    vt[12] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h00, 1'b1, 12'h000, 3'd0, 32'h103};
    vt[13] = '{1'b0, 32'd0, 8'h00, 8'h00, 8'h00, 1'b0, 12'h000, 3'd0, 32'h103};
    vt[14] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h00, 1'b0, 12'h000, 3'd0, 32'h103};
    vt[15] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h00, 1'b0, 12'h000, 3'd0, 32'h103};
    vt[16] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h00, 1'b0, 12'h000, 3'd0, 32'h103};
    vt[17] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h01, 1'b0, 12'h000, 3'd0, 32'h103};
    vt[18] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h01, 1'b1, 12'h501, 3'd1, 32'h203};
    vt[19] = '{1'b0, 32'd1, 8'h00, 8'h00, 8'h01, 1'b0, 12'h000, 3'd0, 32'h203};

    ka_exp[0] = 12'h055;
    ka_exp[1] = 12'hF55;
    ka_exp[2] = 12'hF55;
    ka_exp[3] = 12'hFAA;

    step(2);

    for (int i = 0; i < NV; i++) begin
      reset   = vt[i].rst;
      control = vt[i].ctl;
      config0 = 32'(vt[i].mask);
      config1 = 32'(vt[i].value);
      datain  = vt[i].din;
      step(1);
      chk($sformatf("v%0d we", i), 32'(we), 32'(vt[i].we));
      chk($sformatf("v%0d en", i), 32'(en), 32'(vt[i].we));
      chk($sformatf("v%0d status", i), status, vt[i].st);
      if (vt[i].we) begin
        chk($sformatf("v%0d dataout", i), 32'(dataout), 32'(vt[i].data));
        chk($sformatf("v%0d address", i), 32'(address), 32'(vt[i].addr));
      end
      if (vt[i].rst) begin
        chk($sformatf("v%0d rst dataout", i), 32'(dataout), 32'd0);
        chk($sformatf("v%0d rst address", i), 32'(address), 32'd0);
      end
    end

    // Keep-alive every 16 cycles on a static bus; a change landing on the
    // saturated delta gives a single transition word.
    do_reset(8'h00, 8'h55);
    log_q.delete();
    control = 32'd1;
    step(48);
    datain = 8'hAA;
    step(8);
    control = 32'd2;
    step(1);
    control = 32'd0;
    step(1);
    chk("ka words", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk($sformatf("ka word%0d data", i), 32'(log_q[i].data), 32'(ka_exp[i]));
      chk($sformatf("ka word%0d addr", i), 32'(log_q[i].addr), 32'(i));
    end
    for (int i = 1; i < 4 && i < log_q.size(); i++) begin
      chk($sformatf("ka gap%0d", i), 32'(log_q[i].at - log_q[i-1].at), 32'd16);
    end
    chk("ka status", status, 32'h406);

    // Bus toggling every cycle fills the 8-word buffer.
    do_reset(8'h00, 8'h00);
    log_q.delete();
    control = 32'd1;
    step(1);
    control = 32'd0;
    for (int j = 1; j <= 12; j++) begin
      datain = CH_W'(j % 2);
      step(1);
    end
    chk("full words", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk($sformatf("full word%0d data", i), 32'(log_q[i].data), 32'(i % 2));
      chk($sformatf("full word%0d addr", i), 32'(log_q[i].addr), 32'(i));
    end
    chk("full status", status, 32'h80E);
    chk("full we idle", 32'(we), 32'd0);

    // Abort coinciding with a transition, then a re-arm edge.
    do_reset(8'h00, 8'h00);
    log_q.delete();
    control = 32'd1;
    step(1);
    control = 32'd0;
    step(2);
    datain = 8'h0F;
    step(1);
    control = 32'd2;
    step(1);
    chk("abort we", 32'(we), 32'd0);
    chk("abort status", status, 32'h106);
    control = 32'd0;
    step(1);
    chk("abort words", 32'(log_q.size()), 32'd1);
    control = 32'd1;
    step(1);
    chk("rearm status", status, 32'h011);
    control = 32'd0;

    // Asynchronous reset in the middle of a write pulse.
    do_reset(8'h00, 8'h00);
    control = 32'd1;
    step(2);
    chk("pre-reset we", 32'(we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async we", 32'(we), 32'd0);
    chk("async en", 32'(en), 32'd0);
    chk("async status", status, 32'd0);
    chk("async dataout", 32'(dataout), 32'd0);
    chk("async address", 32'(address), 32'd0);
    log_q.delete();
    control = 32'd0;
    step(2);
    reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      datain = CH_W'(j * 3 + 1);
      step(1);
    end
    chk("post-reset words", 32'(log_q.size()), 32'd0);
    chk("post-reset status", status, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
